key_debounce: RTL and testbench
===============================

KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 Parameter NUM_KEYS, default 2, number of independent pushbutton channels.
REQ-002 Parameter DEBOUNCE_CYCLES, default 250000 (5 ms at 50 MHz), consecutive stable cycles required to accept a level change; legal range >= 2.
REQ-003 Port clk  input  1  single rising-edge clock for all state.
REQ-004 Port rst  input  1  reset, synchronous and active-high.
REQ-005 Port key_n  input  NUM_KEYS  raw board pushbuttons, active-low (0 = pressed), asynchronous to clk, may bounce.
REQ-006 Port key  output  NUM_KEYS  debounced level, active-high (1 = pressed); feeds the downstream key[1:0] consumer directly.
REQ-007 Port key_press  output  NUM_KEYS  one-cycle pulse on the accepted press edge.
REQ-008 Port key_release  output  NUM_KEYS  one-cycle pulse on the accepted release edge.

Function
REQ-009 Each channel SHALL be fully independent; channel i SHALL use only key_n[i].
REQ-010 Each channel SHALL pass key_n[i] through a two-flop synchronizer; the second flop output, inverted, is the sampled level s[i].
REQ-011 Each channel SHALL hold the accepted level key[i] and a counter cnt[i] of width $clog2(DEBOUNCE_CYCLES).
REQ-012 Per cycle, if s[i] == key[i], cnt[i] SHALL load 0.
REQ-013 Per cycle, if s[i] != key[i] and cnt[i] != DEBOUNCE_CYCLES-1, cnt[i] SHALL increment by 1.
REQ-014 Per cycle, if s[i] != key[i] and cnt[i] == DEBOUNCE_CYCLES-1, key[i] SHALL load s[i] and cnt[i] SHALL load 0.
REQ-015 Any single-cycle return of s[i] to key[i] SHALL restart the count from 0; no partial credit is kept.
REQ-016 cnt[i] SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL never wrap.
REQ-017 Latency: a clean raw change first sampled at rising edge 1 SHALL appear on key[i] at rising edge DEBOUNCE_CYCLES+2.
REQ-018 key_press[i] SHALL be registered and high for exactly the one cycle after the edge where key[i] goes 0->1.
REQ-019 key_release[i] SHALL be registered and high for exactly the one cycle after the edge where key[i] goes 1->0.
REQ-020 key_press[i] and key_release[i] SHALL never both be high.
REQ-021 Between accepted transitions, key_press[i] and key_release[i] SHALL be 0.
REQ-022 Simultaneous transitions on different channels SHALL each be accepted on their own timing with no interaction.
REQ-023 Outputs SHALL be driven by flops only; there is no combinational path from key_n to any output.

Reset
REQ-024 While rst is 1 at a rising edge, the synchronizer flops SHALL load 1 (released), and key, key_press, key_release and cnt SHALL load 0.
REQ-025 rst asserted mid-count or mid-pulse SHALL abort the pending change and suppress the pulse; no pulse SHALL be generated by reset itself.
REQ-026 After rst deasserts with key_n held low, the press SHALL be accepted per REQ-017 and SHALL generate key_press.

Verification (DEBOUNCE_CYCLES = 4, NUM_KEYS = 2)
REQ-027 rst held for 3 cycles, key_n=2'b11 -> key=00, key_press=00, key_release=00 throughout and after reset.
REQ-028 key_n[0] 1->0 held, first sampled at edge 1 -> key[0]=1 at edge 6, key_press[0]=1 for exactly one cycle after edge 6, key[1] stays 0.
REQ-029 key_n[0] pulses low for 3 cycles then high -> key[0] stays 0, no key_press pulse.
REQ-030 Bounce pattern on key_n[1]: 0,1,0,1 one cycle each, then steady 0 -> key[1] rises exactly 6 edges after the start of the steady 0 sample, with a single key_press[1].
REQ-031 Both keys pressed in the same cycle, later both released -> key 00->11->00, key_press=11 for one cycle, key_release=11 for one cycle, never press and release together.
REQ-032 rst asserted 2 cycles into a press count -> key stays 00, no pulse; after rst deasserts with key_n held low -> key=1 after DEBOUNCE_CYCLES+2 edges with one press pulse.

Source files
------------

// File: rtl/key_debounce.sv
// Per-key pushbutton debouncer: two-flop synchronizer, stability counter, and
// registered one-cycle press/release pulses on accepted level changes.
module key_debounce #(
  parameter int unsigned NUM_KEYS        = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_n,
  output logic [NUM_KEYS-1:0] key,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic [NUM_KEYS-1:0] sync1_q, sync2_q;
  logic [NUM_KEYS-1:0] sample;
  logic [NUM_KEYS-1:0] key_q, key_d;
  logic [NUM_KEYS-1:0] press_q, press_d;
  logic [NUM_KEYS-1:0] release_q, release_d;
  logic [CntW-1:0]     cnt_q [NUM_KEYS];
  logic [CntW-1:0]     cnt_d [NUM_KEYS];

  // Raw inputs are active-low; sample is the synchronized pressed level.
  assign sample = ~sync2_q;

  always_comb begin
    key_d     = key_q;
    press_d   = '0;
    release_d = '0;
    cnt_d     = cnt_q;
    for (int i = 0; i < int'(NUM_KEYS); i++) begin
      if (sample[i] == key_q[i]) begin
        // Any agreement with the accepted level discards partial progress.
        cnt_d[i] = '0;
      end else if (cnt_q[i] != CntMax) begin
        cnt_d[i] = cnt_q[i] + CntW'(1);
      end else begin
        cnt_d[i]     = '0;
        key_d[i]     = sample[i];
        press_d[i]   = sample[i];
        release_d[i] = ~sample[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= '1;
      sync2_q   <= '1;
      key_q     <= '0;
      press_q   <= '0;
      release_q <= '0;
      for (int i = 0; i < int'(NUM_KEYS); i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q   <= key_n;
      sync2_q   <= sync1_q;
      key_q     <= key_d;
      press_q   <= press_d;
      release_q <= release_d;
      for (int i = 0; i < int'(NUM_KEYS); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign key         = key_q;
  assign key_press   = press_q;
  assign key_release = release_q;

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with DEBOUNCE_CYCLES=4, NUM_KEYS=2.
module tb_key_debounce;

  logic       clk;
  logic       rst;
  logic [1:0] key_n;
  logic [1:0] key;
  logic [1:0] key_press;
  logic [1:0] key_release;

  int n_total;
  int n_pass;

  key_debounce #(
    .NUM_KEYS       (2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_n      (key_n),
    .key        (key),
    .key_press  (key_press),
    .key_release(key_release)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Observed vector is {key, key_press, key_release}.
  task automatic chk(input string tag, input logic [5:0] exp);
    logic [5:0] obs;
    obs = {key, key_press, key_release};
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed={key,press,release}=%b expected=%b", tag, obs, exp);
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    rst     = 1'b1;
    key_n   = 2'b11;

    // Reset held three cycles
    tick(); chk("rst_c1", 6'b00_00_00);
    tick(); chk("rst_c2", 6'b00_00_00);
    tick(); chk("rst_c3", 6'b00_00_00);
    rst = 1'b0;
    tick(); chk("post_rst", 6'b00_00_00);
    tick(); chk("idle", 6'b00_00_00);

    // Clean press on key 0: accepted at edge 6
    key_n = 2'b10;
    for (int e = 1; e <= 5; e++) begin
      tick(); chk($sformatf("press0_e%0d", e), 6'b00_00_00);
    end
    tick(); chk("press0_e6", 6'b01_01_00);
    tick(); chk("press0_e7", 6'b01_00_00);

    // Clean release on key 0
    key_n = 2'b11;
    for (int e = 1; e <= 5; e++) begin
      tick(); chk($sformatf("rel0_e%0d", e), 6'b01_00_00);
    end
    tick(); chk("rel0_e6", 6'b00_00_01);
    tick(); chk("rel0_e7", 6'b00_00_00);

    // Three-cycle glitch on key 0 must be rejected
    key_n = 2'b10;
    tick(); tick(); tick();
    key_n = 2'b11;
    for (int e = 1; e <= 8; e++) begin
      tick(); chk($sformatf("glitch0_e%0d", e), 6'b00_00_00);
    end

    // Bounce 0,1,0,1 on key 1, then steady 0
    key_n = 2'b01; tick();
    key_n = 2'b11; tick();
    key_n = 2'b01; tick();
    key_n = 2'b11; tick();
    key_n = 2'b01;
    for (int e = 1; e <= 5; e++) begin
      tick(); chk($sformatf("bounce1_e%0d", e), 6'b00_00_00);
    end
    tick(); chk("bounce1_e6", 6'b10_10_00);
    tick(); chk("bounce1_e7", 6'b10_00_00);
    key_n = 2'b11;
    for (int e = 1; e <= 5; e++) tick();
    tick(); chk("rel1_e6", 6'b00_00_10);
    tick(); chk("rel1_e7", 6'b00_00_00);

    // Both keys together
    key_n = 2'b00;
    for (int e = 1; e <= 5; e++) begin
      tick(); chk($sformatf("both_e%0d", e), 6'b00_00_00);
    end
    tick(); chk("both_press", 6'b11_11_00);
    tick(); chk("both_held", 6'b11_00_00);
    key_n = 2'b11;
    for (int e = 1; e <= 5; e++) begin
      tick(); chk($sformatf("both_rel_e%0d", e), 6'b11_00_00);
    end
    tick(); chk("both_release", 6'b00_00_11);
    tick(); chk("both_idle", 6'b00_00_00);

    // Reset two cycles into a count on key 0, key held through
    key_n = 2'b10;
    tick(); tick(); tick(); tick();
    rst = 1'b1;
    tick(); chk("midrst_c1", 6'b00_00_00);
    tick(); chk("midrst_c2", 6'b00_00_00);
    rst = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      tick(); chk($sformatf("after_rst_e%0d", e), 6'b00_00_00);
    end
    tick(); chk("after_rst_e6", 6'b01_01_00);
    tick(); chk("after_rst_e7", 6'b01_00_00);

    // Reset in the pulse cycle suppresses it and drops the level
    key_n = 2'b11;
    for (int e = 1; e <= 5; e++) tick();
    rst = 1'b1;
    tick(); chk("rst_pulse", 6'b00_00_00);
    rst = 1'b0;
    tick(); chk("rst_pulse_after", 6'b00_00_00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
